// File: rtl/debug_pkg.sv
// Shared defaults and event-record layout helpers for the debug event scheduler.
// Record packing, LSB first: seq | data | ch | ts (ts only with DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN).
package debug_pkg;
  localparam int NUM_CH_DEF     = 4;
  localparam int DATA_W_DEF     = 4;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int SEQ_W_DEF      = 8;
  localparam int DROP_W         = 8;
`ifdef DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN
  localparam int TS_W_DEF       = 16;
`endif

  function automatic int ch_width(input int num_ch);
    return (num_ch < 2) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int data_lsb(input int seq_w);
    return seq_w;
  endfunction

  function automatic int ch_lsb(input int seq_w, input int data_w);
    return seq_w + data_w;
  endfunction

  function automatic int ts_lsb(input int seq_w, input int data_w, input int ch_w);
    return seq_w + data_w + ch_w;
  endfunction
endpackage

// File: rtl/debug_event_fifo.sv
// Single-clock event FIFO with count/full/empty; the head word reads as zero while empty.
module debug_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/debug_event_scheduler.sv
// Collects per-channel debugger trigger events, grants them round-robin into a FIFO and streams them out.
// Optional per-event capture timestamp: define DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN.
module debug_event_scheduler
  import debug_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SEQ_W      = SEQ_W_DEF,
`ifdef DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN
  parameter int TS_W       = TS_W_DEF,
`endif
  localparam int CH_W      = ch_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        trig,
  input  logic [NUM_CH*DATA_W-1:0] data,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [CH_W-1:0]          ev_ch,
  output logic [DATA_W-1:0]        ev_data,
  output logic [SEQ_W-1:0]         ev_seq,
`ifdef DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN
  output logic [TS_W-1:0]          ev_ts,
`endif
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int DATA_LSB = data_lsb(SEQ_W);
  localparam int CH_LSB   = ch_lsb(SEQ_W, DATA_W);
`ifdef DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN
  localparam int TS_LSB   = ts_lsb(SEQ_W, DATA_W, CH_W);
  localparam int EV_W     = TS_LSB + TS_W;
`else
  localparam int EV_W     = CH_LSB + CH_W;
`endif

  logic [NUM_CH-1:0] r_pend;
  logic [DATA_W-1:0] r_pend_data [NUM_CH];
  logic [CH_W-1:0]   r_ptr;
  logic [SEQ_W-1:0]  r_seq;
  logic [DROP_W-1:0] r_drop;

  logic              w_can_push;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_ch;
  logic [CH_W-1:0]   w_idx;
  logic [NUM_CH-1:0] w_gnt_oh;
  logic [NUM_CH-1:0] w_drop_vec;
  logic [DROP_W:0]   w_drop_n;
  logic [DROP_W:0]   w_drop_sum;
  logic [DROP_W-1:0] w_drop_next;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic [EV_W-1:0]   w_wr_data;
  logic [EV_W-1:0]   w_rd_data;

  assign w_can_push = (w_count < CNT_W'(FIFO_DEPTH));

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_gnt_vld && w_can_push && r_pend[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = w_idx;
      end
    end
  end

  assign w_gnt_oh   = w_gnt_vld ? (NUM_CH'(1) << w_gnt_ch) : '0;
  assign w_drop_vec = trig & r_pend & ~w_gnt_oh;

  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_drop_n = w_drop_n + (DROP_W+1)'(w_drop_vec[i]);
    end
  end

  assign w_drop_sum  = {1'b0, r_drop} + w_drop_n;
  assign w_drop_next = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];

  // A trigger always wins over the clear from its own grant: the granted entry takes the old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      for (int i = 0; i < NUM_CH; i++) r_pend_data[i] <= '0;
      r_ptr  <= CH_W'(NUM_CH - 1);
      r_seq  <= '0;
      r_drop <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (trig[i]) begin
          r_pend[i]      <= 1'b1;
          r_pend_data[i] <= data[i*DATA_W +: DATA_W];
        end else if (w_gnt_oh[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
      if (w_gnt_vld) begin
        r_ptr <= w_gnt_ch;
        r_seq <= r_seq + 1'b1;
      end
      r_drop <= w_drop_next;
    end
  end

`ifdef DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_pend_ts [NUM_CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts_cnt <= '0;
      for (int i = 0; i < NUM_CH; i++) r_pend_ts[i] <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (trig[i]) r_pend_ts[i] <= r_ts_cnt;
      end
    end
  end

  assign w_wr_data = {r_pend_ts[w_gnt_ch], w_gnt_ch, r_pend_data[w_gnt_ch], r_seq};
  assign ev_ts     = w_rd_data[TS_LSB +: TS_W];
`else
  assign w_wr_data = {w_gnt_ch, r_pend_data[w_gnt_ch], r_seq};
`endif

  debug_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_gnt_vld),
    .i_wr_data (w_wr_data),
    .i_pop     (ev_ready),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) assert (w_full == (w_count == CNT_W'(FIFO_DEPTH)));
  end

  assign ev_valid = ~w_empty;
  assign ev_seq   = w_rd_data[SEQ_W-1:0];
  assign ev_data  = w_rd_data[DATA_LSB +: DATA_W];
  assign ev_ch    = w_rd_data[CH_LSB +: CH_W];
  assign drop_cnt = r_drop;
endmodule

// File: tb/tb_debug_event_scheduler.sv
// Randomised and directed bench for debug_event_scheduler against a queue-based event model.
module tb_debug_event_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  trig = '0;
  logic [15:0] data = '0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [1:0]  ev_ch;
  logic [3:0]  ev_data;
  logic [7:0]  ev_seq;
  logic [7:0]  drop_cnt;
`ifdef DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN
  logic [15:0] ev_ts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  debug_event_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .trig     (trig),
    .data     (data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ch    (ev_ch),
    .ev_data  (ev_data),
    .ev_seq   (ev_seq),
`ifdef DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN
    .ev_ts    (ev_ts),
`endif
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending slots per channel plus a queue of events.
  typedef struct {int ch; int data; int seq; int ts;} ev_t;
  ev_t mq[$];
  bit  m_pend [4];
  int  m_pd   [4];
  int  m_pts  [4];
  int  m_ptr, m_seq, m_drop, m_ts;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_pd[i] = 0; m_pts[i] = 0; end
      m_ptr = 3; m_seq = 0; m_drop = 0; m_ts = 0;
    end else begin
      int g;
      ev_t e;
      g = -1;
      if (mq.size() < 8) begin
        for (int k = 1; k <= 4; k++) begin
          if (g < 0 && m_pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
      end
      if (ev_ready && mq.size() > 0) e = mq.pop_front();
      if (g >= 0) begin
        e.ch = g; e.data = m_pd[g]; e.seq = m_seq; e.ts = m_pts[g];
        mq.push_back(e);
        m_seq = (m_seq + 1) % 256;
        m_ptr = g;
      end
      for (int i = 0; i < 4; i++) begin
        if (trig[i]) begin
          if (m_pend[i] && i != g && m_drop < 255) m_drop++;
          m_pend[i] = 1;
          m_pd[i]   = int'(data[i*4 +: 4]);
          m_pts[i]  = m_ts;
        end else if (i == g) begin
          m_pend[i] = 0;
        end
      end
      m_ts = (m_ts + 1) % 65536;
    end
  end

  int dut_pops = 0;
  int last_seq = -1;
  bit saw_wrap = 0;

  always @(negedge clk) begin
    if (!reset) begin
      chk("ev_valid", ev_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("ev_ch", ev_ch, mq[0].ch);
        chk("ev_data", ev_data, mq[0].data);
        chk("ev_seq", ev_seq, mq[0].seq);
`ifdef DEBUG_EVENT_SCHEDULER_TIMESTAMP_EN
        chk("ev_ts", ev_ts, mq[0].ts);
`endif
      end
      chk("drop_cnt", drop_cnt, m_drop);
      if (ev_valid && ev_ready) begin
        dut_pops++;
        if (last_seq == 255 && ev_seq == 8'd0) saw_wrap = 1;
        last_seq = int'(ev_seq);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; trig = '0; data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic fill8();
    for (int k = 0; k < 8; k++) begin
      tick(); trig = 4'b0001; data = 16'(k);
      tick(); trig = '0;
    end
    tick(); tick(); tick();
  endtask

  task automatic head(input string name, input int ch, input int d, input int s);
    chk({name, ".valid"}, ev_valid, 1);
    chk({name, ".ch"}, ev_ch, ch);
    chk({name, ".data"}, ev_data, d);
    chk({name, ".seq"}, ev_seq, s);
  endtask

  initial begin
    int mode;
    logic [3:0] t;
    mode = 0;

    do_reset();
    tick();
    chk("rst.valid", ev_valid, 0);
    chk("rst.ch", ev_ch, 0);
    chk("rst.data", ev_data, 0);
    chk("rst.seq", ev_seq, 0);
    chk("rst.drop", drop_cnt, 0);

    // single event on ch2
    ev_ready = 1'b1;
    tick(); trig = 4'b0100; data = 16'h0A00;
    tick(); trig = '0;
    chk("single.t1_valid", ev_valid, 0);
    tick(); head("single", 2, 10, 0);
    tick(); chk("single.one_beat", ev_valid, 0);

    // all channels at once
    do_reset();
    ev_ready = 1'b1;
    tick(); trig = 4'b1111; data = 16'h4321;
    tick(); trig = '0;
    for (int k = 0; k < 4; k++) begin
      tick(); head("allch", k, k + 1, k);
    end
    tick();
    chk("allch.end", ev_valid, 0);
    chk("allch.drop", drop_cnt, 0);

    // overwrite while full
    do_reset();
    ev_ready = 1'b0;
    fill8();
    tick(); trig = 4'b0010; data = 16'h0050;
    tick(); data = 16'h0060;
    tick(); trig = '0;
    chk("ovw.drop", drop_cnt, 1);
    ev_ready = 1'b1;
    head("ovw.e0", 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) head("ovw.ek", 0, k, k);
      else       head("ovw.ch1", 1, 6, 8);
    end
    tick();
    chk("ovw.end", ev_valid, 0);

    // trigger coinciding with its own grant
    do_reset();
    ev_ready = 1'b1;
    tick(); trig = 4'b0100; data = 16'h0300;
    tick(); data = 16'h0400;
    tick(); trig = '0;
    head("coinc.old", 2, 3, 0);
    tick(); head("coinc.new", 2, 4, 1);
    tick();
    chk("coinc.end", ev_valid, 0);
    chk("coinc.drop", drop_cnt, 0);

    // sequence wrap
    do_reset();
    ev_ready = 1'b1;
    dut_pops = 0; last_seq = -1; saw_wrap = 0;
    for (int k = 0; k < 257; k++) begin
      tick(); trig = 4'(1 << (k % 4)); data = 16'($urandom);
    end
    tick(); trig = '0;
    repeat (6) tick();
    chk("wrap.pops", dut_pops, 257);
    chk("wrap.seen", saw_wrap, 1);

    // drop counter saturation
    do_reset();
    ev_ready = 1'b0;
    fill8();
    for (int k = 0; k < 301; k++) begin
      tick(); trig = 4'b1000; data = 16'($urandom);
    end
    tick(); trig = '0;
    chk("sat.drop", drop_cnt, 255);
    ev_ready = 1'b1;
    repeat (12) tick();

    // reset with 5 queued and 2 pending
    do_reset();
    ev_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(); trig = 4'b0001; data = 16'(k);
    end
    tick(); trig = 4'b0110; data = 16'h0770;
    @(posedge clk); #2;
    chk("midrst.queued", mq.size(), 5);
    reset = 1'b1;
    #1;
    chk("midrst.valid", ev_valid, 0);
    chk("midrst.seq", ev_seq, 0);
    tick(); trig = '0;
    tick();
    reset = 1'b0;
    ev_ready = 1'b1;
    tick(); chk("midrst.no_stale", ev_valid, 0);
    trig = 4'b1000; data = 16'h9000;
    tick(); trig = '0;
    tick(); head("midrst.first", 3, 9, 0);
    tick();

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 150 == 0) mode = int'($urandom_range(0, 3));
      ev_ready = (mode == 0) ? 1'b0 : ((mode == 3) ? 1'b1 : ($urandom_range(0, 1) == 1));
      for (int i = 0; i < 4; i++) t[i] = ($urandom_range(0, 3) == 0);
      trig = t;
      data = 16'($urandom);
    end
    tick(); trig = '0; ev_ready = 1'b1;
    repeat (20) tick();
    chk("final.empty", ev_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
